// File: rtl/spi_slave_byte_if.sv
// Byte-side bus between the SPI slave byte engine and the command FSM.
// The slave modport is the engine; the master modport is its consumer.
interface spi_slave_byte_if;
   logic       spi_byte_o_en;
   logic [7:0] spi_byte_o;
   logic       spi_byte_i_en;
   logic [7:0] spi_byte_i;
   logic       tx_underrun;
   logic       tx_overrun;

   modport slave (
      output spi_byte_o_en,
      output spi_byte_o,
      output tx_underrun,
      output tx_overrun,
      input  spi_byte_i_en,
      input  spi_byte_i
   );

   modport master (
      input  spi_byte_o_en,
      input  spi_byte_o,
      input  tx_underrun,
      input  tx_overrun,
      output spi_byte_i_en,
      output spi_byte_i
   );
endinterface

// File: rtl/spi_slave_byte.sv
// SPI mode-0 slave byte engine. Oversamples the raw SPI pins in the up_clk
// domain, deserializes MOSI into byte strobes and serializes a single-entry
// transmit holding register onto MISO. Chip select doubles as session reset.
module spi_slave_byte #(
   parameter int         SYNC_STAGES  = 2,
   parameter logic [7:0] TX_IDLE_BYTE = 8'h00
) (
   input  logic             up_clk,
   input  logic             up_rst_n,
   input  logic             spi_sck_pin,
   input  logic             spi_mosi_pin,
   input  logic             spi_cs_n_pin,
   output logic             spi_miso,
   output logic             spi_miso_oe,
   output logic             spi_cs,
   spi_slave_byte_if.slave  bus
);

   // synchronizer chains (index 0 is the first flop after the pin)
   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic                   sck_hist_q, sck_hist_d;
   logic                   cs_hist_q, cs_hist_d;

   // receive path
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] rx_q, rx_d;
   logic       byte_done_q, byte_done_d;
   logic [7:0] byte_o_q, byte_o_d;
   logic       byte_o_en_q, byte_o_en_d;

   // transmit path
   logic [7:0] hold_q, hold_d;
   logic       hold_vld_q, hold_vld_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic       miso_q, miso_d;
   logic       underrun_q, underrun_d;
   logic       overrun_q, overrun_d;

   // decoded pin events
   logic sck_s, mosi_s, cs_s;
   logic sck_rise_s, sck_fall_s;
   logic active_s, start_s, load_s;

   assign sck_s      = sck_sync_q[SYNC_STAGES-1];
   assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
   assign cs_s       = cs_sync_q[SYNC_STAGES-1];
   assign active_s   = ~cs_s;
   assign sck_rise_s = sck_s & ~sck_hist_q;
   assign sck_fall_s = ~sck_s & sck_hist_q;
   // session start, or the falling edge that follows the eighth rise
   assign start_s    = ~cs_s & cs_hist_q;
   assign load_s     = start_s | (active_s & sck_fall_s & (bit_cnt_q == 3'd0));

   // Shift every pin through its synchronizer; SCK and CS also keep one history bit.
   always_comb begin
      sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck_pin};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_pin};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_pin};
      sck_hist_d  = sck_s;
      cs_hist_d   = cs_s;
   end

   // Receive: shift MOSI in on SCK rises, flag the completed byte, strobe it a cycle later.
   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      rx_d        = rx_q;
      byte_done_d = 1'b0;
      byte_o_en_d = byte_done_q;
      if (byte_done_q) begin
         byte_o_d = rx_q;
      end else begin
         byte_o_d = byte_o_q;
      end
      if (cs_s) begin
         bit_cnt_d = 3'd0;
         rx_d      = 8'h00;
      end else if (sck_rise_s) begin
         rx_d        = {rx_q[6:0], mosi_s};
         bit_cnt_d   = bit_cnt_q + 3'd1;
         byte_done_d = (bit_cnt_q == 3'd7);
      end else begin
         bit_cnt_d = bit_cnt_q;
         rx_d      = rx_q;
      end
   end

   // Transmit: holding register, load-event source selection, and MISO shifting.
   always_comb begin
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      tx_shift_d = tx_shift_q;
      underrun_d = 1'b0;
      overrun_d  = 1'b0;
      miso_d     = tx_shift_q[7];
      if (load_s) begin
         // a strobe in the load cycle goes straight out and never counts as overrun
         if (bus.spi_byte_i_en) begin
            tx_shift_d = bus.spi_byte_i;
            hold_vld_d = 1'b0;
         end else if (hold_vld_q) begin
            tx_shift_d = hold_q;
            hold_vld_d = 1'b0;
         end else begin
            tx_shift_d = TX_IDLE_BYTE;
            underrun_d = 1'b1;
         end
      end else begin
         if (bus.spi_byte_i_en) begin
            hold_d     = bus.spi_byte_i;
            hold_vld_d = 1'b1;
            overrun_d  = hold_vld_q;
         end else begin
            hold_vld_d = hold_vld_q;
         end
         if (active_s && sck_fall_s) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
         end else begin
            tx_shift_d = tx_shift_q;
         end
      end
   end

   // State register with synchronous active-low reset to idle pin levels.
   always_ff @(posedge up_clk) begin
      if (!up_rst_n) begin
         sck_sync_q  <= {SYNC_STAGES{1'b0}};
         mosi_sync_q <= {SYNC_STAGES{1'b0}};
         cs_sync_q   <= {SYNC_STAGES{1'b1}};
         sck_hist_q  <= 1'b0;
         cs_hist_q   <= 1'b1;
         bit_cnt_q   <= 3'd0;
         rx_q        <= 8'h00;
         byte_done_q <= 1'b0;
         byte_o_q    <= 8'h00;
         byte_o_en_q <= 1'b0;
         hold_q      <= 8'h00;
         hold_vld_q  <= 1'b0;
         tx_shift_q  <= 8'h00;
         miso_q      <= 1'b0;
         underrun_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         sck_sync_q  <= sck_sync_d;
         mosi_sync_q <= mosi_sync_d;
         cs_sync_q   <= cs_sync_d;
         sck_hist_q  <= sck_hist_d;
         cs_hist_q   <= cs_hist_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_q        <= rx_d;
         byte_done_q <= byte_done_d;
         byte_o_q    <= byte_o_d;
         byte_o_en_q <= byte_o_en_d;
         hold_q      <= hold_d;
         hold_vld_q  <= hold_vld_d;
         tx_shift_q  <= tx_shift_d;
         miso_q      <= miso_d;
         underrun_q  <= underrun_d;
         overrun_q   <= overrun_d;
      end
   end

   assign spi_cs            = cs_s;
   assign spi_miso_oe       = ~cs_s;
   assign spi_miso          = miso_q;
   assign bus.spi_byte_o_en = byte_o_en_q;
   assign bus.spi_byte_o    = byte_o_q;
   assign bus.tx_underrun   = underrun_q;
   assign bus.tx_overrun    = overrun_q;

endmodule

// File: tb/tb_spi_slave_byte.sv
// Self-checking bench for spi_slave_byte: an SPI master with SCK at up_clk/8,
// directed sessions followed by randomized ones, checked against a
// transaction-level model of the receive strobes and transmit byte selection.
module tb_spi_slave_byte;

   logic up_clk       = 1'b0;
   logic up_rst_n     = 1'b0;
   logic spi_sck_pin  = 1'b0;
   logic spi_mosi_pin = 1'b0;
   logic spi_cs_n_pin = 1'b1;
   logic spi_miso, spi_miso_oe, spi_cs;

   spi_slave_byte_if bus ();

   spi_slave_byte dut (
      .up_clk       (up_clk),
      .up_rst_n     (up_rst_n),
      .spi_sck_pin  (spi_sck_pin),
      .spi_mosi_pin (spi_mosi_pin),
      .spi_cs_n_pin (spi_cs_n_pin),
      .spi_miso     (spi_miso),
      .spi_miso_oe  (spi_miso_oe),
      .spi_cs       (spi_cs),
      .bus          (bus)
   );

   always #5 up_clk = ~up_clk;

   int n_tot = 0;
   int n_bad = 0;

   // pulse counters observed on the DUT outputs
   int strb_cnt = 0;
   int unr_cnt  = 0;
   int ovr_cnt  = 0;

   // reference model: one-entry holding register plus expected pulse counts
   logic [7:0] m_hold     = 8'h00;
   bit         m_hold_vld = 1'b0;
   int         m_strb     = 0;
   int         m_unr      = 0;
   int         m_ovr      = 0;

   // per-session stimulus
   logic [7:0] mo_a [8];
   logic [7:0] cv_a [8];
   logic [7:0] mv_a [8];
   bit         col_a[8];
   bit         mid_a[8];

   // count output pulses away from the active edge
   always @(negedge up_clk) begin
      if (up_rst_n) begin
         if (bus.spi_byte_o_en) strb_cnt <= strb_cnt + 1;
         if (bus.tx_underrun)   unr_cnt  <= unr_cnt + 1;
         if (bus.tx_overrun)    ovr_cnt  <= ovr_cnt + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge up_clk);
      #1;
   endtask

   // model: a load event picks the strobed byte, else the held byte, else idle
   task automatic m_load(input bit col, input logic [7:0] cv, output logic [7:0] nb);
      if (col) begin
         nb = cv;
         m_hold_vld = 1'b0;
      end else if (m_hold_vld) begin
         nb = m_hold;
         m_hold_vld = 1'b0;
      end else begin
         nb = 8'h00;
         m_unr++;
      end
   endtask

   // model: a write outside a load event lands in the holding register
   task automatic m_write(input logic [7:0] v);
      if (m_hold_vld) m_ovr++;
      m_hold     = v;
      m_hold_vld = 1'b1;
   endtask

   task automatic pulse_in(input logic [7:0] v);
      bus.spi_byte_i    = v;
      bus.spi_byte_i_en = 1'b1;
      tick();
      bus.spi_byte_i_en = 1'b0;
      m_write(v);
   endtask

   task automatic clr_cfg();
      for (int i = 0; i < 8; i++) begin
         mo_a[i] = 8'h00; cv_a[i] = 8'h00; mv_a[i] = 8'h00;
         col_a[i] = 1'b0; mid_a[i] = 1'b0;
      end
   endtask

   // One byte (or nbits bits) as master. Each bit: 4 up_clk low, 4 high.
   // col strobes cv into the load event caused by the preceding SCK fall;
   // mid strobes mv during bit 3.
   task automatic xfer_byte(input logic [7:0] mo, input bit col, input logic [7:0] cv,
                            input bit mid, input logic [7:0] mv, input int nbits,
                            output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi_pin = mo[7-i];
         if (i == 0 && col) begin
            tick(); tick();
            bus.spi_byte_i    = cv;
            bus.spi_byte_i_en = 1'b1;
            tick();
            bus.spi_byte_i_en = 1'b0;
            tick();
         end else begin
            repeat (4) tick();
         end
         mi[7-i] = spi_miso;
         spi_sck_pin = 1'b1;
         tick();
         if (mid && i == 3) begin
            bus.spi_byte_i    = mv;
            bus.spi_byte_i_en = 1'b1;
         end
         tick();
         bus.spi_byte_i_en = 1'b0;
         tick();
         if (i == 7) check_eq("strb_early", {31'd0, bus.spi_byte_o_en}, 32'd0);
         tick();
         if (i == 7) begin
            check_eq("strb_lat", {31'd0, bus.spi_byte_o_en}, 32'd1);
            check_eq("rx_byte", {24'd0, bus.spi_byte_o}, {24'd0, mo});
         end
         spi_sck_pin = 1'b0;
      end
   endtask

   task automatic check_counts(input string tag);
      check_eq({tag, "_strb"}, strb_cnt, m_strb);
      check_eq({tag, "_unr"},  unr_cnt,  m_unr);
      check_eq({tag, "_ovr"},  ovr_cnt,  m_ovr);
   endtask

   task automatic run_session(input string tag, input int nb);
      logic [7:0] expb, got;
      spi_cs_n_pin = 1'b0;
      m_load(1'b0, 8'h00, expb);
      repeat (6) tick();
      check_eq({tag, "_oe"}, {31'd0, spi_miso_oe}, 32'd1);
      for (int k = 0; k < nb; k++) begin
         if (k > 0) m_load(col_a[k], cv_a[k], expb);
         xfer_byte(mo_a[k], (k > 0) && col_a[k], cv_a[k], mid_a[k], mv_a[k], 8, got);
         m_strb++;
         if (mid_a[k]) m_write(mv_a[k]);
         check_eq({tag, "_miso"}, {24'd0, got}, {24'd0, expb});
      end
      m_load(1'b0, 8'h00, expb);   // the fall after the last byte is a load event too
      repeat (4) tick();
      spi_cs_n_pin = 1'b1;
      repeat (6) tick();
      check_eq({tag, "_cs"}, {31'd0, spi_cs}, 32'd1);
      check_counts(tag);
   endtask

   initial begin
      logic [7:0] e, g;
      bus.spi_byte_i_en = 1'b0;
      bus.spi_byte_i    = 8'h00;

      // reset with the pins toggling
      up_rst_n = 1'b0;
      for (int i = 0; i < 12; i++) begin
         spi_sck_pin  = 1'($urandom_range(0, 1));
         spi_mosi_pin = 1'($urandom_range(0, 1));
         spi_cs_n_pin = 1'($urandom_range(0, 1));
         tick();
         check_eq("reset_outs",
                  {17'd0, spi_cs, spi_miso, spi_miso_oe, bus.spi_byte_o_en, bus.spi_byte_o,
                   bus.tx_underrun, bus.tx_overrun},
                  {17'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
      end
      spi_sck_pin = 1'b0; spi_mosi_pin = 1'b0; spi_cs_n_pin = 1'b1;
      repeat (2) tick();
      up_rst_n = 1'b1;
      repeat (4) tick();
      check_eq("idle_cs", {31'd0, spi_cs}, 32'd1);
      check_counts("idle");

      // receive two bytes
      clr_cfg();
      mo_a[0] = 8'hA5; mo_a[1] = 8'h3C;
      run_session("rx", 2);

      // transmit: preloaded byte, then a byte loaded mid-byte
      clr_cfg();
      pulse_in(8'h5A);
      mo_a[0] = 8'h12; mo_a[1] = 8'h34;
      mid_a[0] = 1'b1; mv_a[0] = 8'hC3;
      run_session("tx", 2);

      // underrun with nothing loaded
      clr_cfg();
      mo_a[0] = 8'h81;
      run_session("unr", 1);

      // overrun: second write replaces the first
      clr_cfg();
      pulse_in(8'h11);
      pulse_in(8'h22);
      mo_a[0] = 8'h5F;
      run_session("ovr", 1);

      // collision: a strobe in the load cycle wins over the held byte
      clr_cfg();
      mo_a[0] = 8'h0F; mo_a[1] = 8'hF0;
      mid_a[0] = 1'b1; mv_a[0] = 8'h44;
      col_a[1] = 1'b1; cv_a[1] = 8'h77;
      run_session("col", 2);

      // abort after 5 bits, then a clean 0xFF session
      spi_cs_n_pin = 1'b0;
      m_load(1'b0, 8'h00, e);
      repeat (6) tick();
      xfer_byte(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 5, g);
      repeat (2) tick();
      spi_cs_n_pin = 1'b1;
      repeat (8) tick();
      check_counts("abort");
      clr_cfg();
      mo_a[0] = 8'hFF;
      run_session("fresh", 1);

      // randomized sessions
      for (int s = 0; s < 20; s++) begin
         int nb;
         clr_cfg();
         nb = int'($urandom_range(1, 4));
         for (int k = 0; k < nb; k++) begin
            mo_a[k]  = 8'($urandom);
            cv_a[k]  = 8'($urandom);
            mv_a[k]  = 8'($urandom);
            col_a[k] = 1'($urandom_range(0, 1));
            mid_a[k] = 1'($urandom_range(0, 1));
         end
         for (int p = int'($urandom_range(0, 2)); p > 0; p--) begin
            pulse_in(8'($urandom));
            tick();
         end
         run_session("rand", nb);
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
